// File: rtl/next_pc_unit.sv
// Next-PC selection with a circular return-address stack for JAL/RET.
// Chooses between hold, branch, jump/return and sequential, and latches a halt.
`timescale 1ns/1ps
module next_pc_unit #(
  parameter int              PC_W      = 16,
  parameter int              RAS_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_PC  = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [1:0]      Type,
  input  logic [4:0]      OPCode,
  input  logic            Zero,
  input  logic            Stall,
  input  logic            Stop,
  input  logic [PC_W-1:0] branch_target,
  input  logic [PC_W-1:0] jump_target,
  output logic [PC_W-1:0] pc,
  output logic [1:0]      PcSrc,
  output logic            halted,
  output logic            ras_empty,
  output logic            ras_full,
  output logic            ras_overflow,
  output logic            ras_underflow
);

  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  localparam logic [PC_W-1:0]  PC_ONE  = PC_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RAS_DEPTH);

  localparam logic [1:0] TY_R      = 2'b00;
  localparam logic [1:0] TY_JUMP   = 2'b01;
  localparam logic [1:0] TY_BRANCH = 2'b10;

  localparam logic [4:0] OP_J   = 5'b00000;
  localparam logic [4:0] OP_JAL = 5'b00001;
  localparam logic [4:0] OP_RET = 5'b00011;
  localparam logic [4:0] OP_BEQ = 5'b00100;
  localparam logic [4:0] OP_BNE = 5'b00101;

  localparam logic [1:0] SRC_HOLD   = 2'b00;
  localparam logic [1:0] SRC_BRANCH = 2'b01;
  localparam logic [1:0] SRC_JUMP   = 2'b10;
  localparam logic [1:0] SRC_SEQ    = 2'b11;

  logic [PC_W-1:0]  pc_q, pc_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             halted_q, halted_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [PC_W-1:0]  ras_q [RAS_DEPTH];

  logic [PC_W-1:0]  pc_inc;
  logic [PTR_W-1:0] rd_ptr;
  logic             empty, full;
  logic             is_beq, is_bne, is_j, is_jal, is_ret;
  logic             push;
  logic [1:0]       src;

  assign pc_inc = pc_q + PC_ONE;
  // wr_ptr_q points at the next free slot, so the top of stack sits one below it.
  assign rd_ptr = wr_ptr_q - PTR_ONE;
  assign empty  = (cnt_q == '0);
  assign full   = (cnt_q == DEPTH_C);

  assign is_beq = (Type == TY_BRANCH) && (OPCode == OP_BEQ);
  assign is_bne = (Type == TY_BRANCH) && (OPCode == OP_BNE);
  assign is_j   = (Type == TY_JUMP)   && (OPCode == OP_J);
  assign is_jal = (Type == TY_JUMP)   && (OPCode == OP_JAL);
  assign is_ret = (Type == TY_R)      && (OPCode == OP_RET);

  always_comb begin
    src      = SRC_HOLD;
    pc_d     = pc_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    halted_d = halted_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    push     = 1'b0;
    if (reset) begin
      src = SRC_HOLD;
    end else if (halted_q || Stop) begin
      halted_d = 1'b1;
    end else if (Stall) begin
      src = SRC_HOLD;
    end else if ((is_beq && Zero) || (is_bne && !Zero)) begin
      src  = SRC_BRANCH;
      pc_d = branch_target;
    end else if (is_j) begin
      src  = SRC_JUMP;
      pc_d = jump_target;
    end else if (is_jal) begin
      src      = SRC_JUMP;
      pc_d     = jump_target;
      push     = 1'b1;
      wr_ptr_d = wr_ptr_q + PTR_ONE;
      // A full stack drops its oldest entry: the circular write lands on it.
      if (full) begin
        ovf_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end else if (is_ret && !empty) begin
      src      = SRC_JUMP;
      pc_d     = ras_q[rd_ptr];
      wr_ptr_d = rd_ptr;
      cnt_d    = cnt_q - CNT_ONE;
    end else begin
      src  = SRC_SEQ;
      pc_d = pc_inc;
      if (is_ret) begin
        unf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      halted_q <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      halted_q <= halted_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Entry storage carries no reset; count and pointer alone define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      ras_q[wr_ptr_q] <= pc_inc;
    end
  end

  assign pc            = pc_q;
  assign PcSrc         = src;
  assign halted        = halted_q;
  assign ras_empty     = empty;
  assign ras_full      = full;
  assign ras_overflow  = ovf_q;
  assign ras_underflow = unf_q;

endmodule

// File: tb/tb_next_pc_unit.sv
// Directed bench for next_pc_unit: driver queues hand-computed expectations,
// a monitor compares PcSrc before each edge and pc/flags after it.
`timescale 1ns/1ps
module tb_next_pc_unit;

  localparam logic [1:0] TR = 2'b00, TJ = 2'b01, TB = 2'b10, TO = 2'b11;
  localparam logic [4:0] OP_J = 5'b00000, OP_JAL = 5'b00001, OP_RET = 5'b00011;
  localparam logic [4:0] OP_BEQ = 5'b00100, OP_BNE = 5'b00101;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  Type;
  logic [4:0]  OPCode;
  logic        Zero, Stall, Stop;
  logic [15:0] branch_target, jump_target;
  logic [15:0] pc;
  logic [1:0]  PcSrc;
  logic        halted, ras_empty, ras_full, ras_overflow, ras_underflow;

  typedef struct {
    string       name;
    logic [1:0]  src;
    logic [15:0] pc;
    logic [4:0]  fl;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  next_pc_unit dut (
    .clk(clk), .reset(reset), .Type(Type), .OPCode(OPCode), .Zero(Zero),
    .Stall(Stall), .Stop(Stop), .branch_target(branch_target),
    .jump_target(jump_target), .pc(pc), .PcSrc(PcSrc), .halted(halted),
    .ras_empty(ras_empty), .ras_full(ras_full), .ras_overflow(ras_overflow),
    .ras_underflow(ras_underflow)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] flags();
    return {halted, ras_empty, ras_full, ras_overflow, ras_underflow};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask

  // Drive one instruction for one cycle and queue its expected outcome.
  task automatic st(input string nm, input logic [1:0] ty, input logic [4:0] op,
                    input logic z, input logic stl, input logic stp,
                    input logic [15:0] bt, input logic [15:0] jt,
                    input logic [1:0] esrc, input logic [15:0] epc, input logic [4:0] efl);
    exp_t it;
    Type = ty; OPCode = op; Zero = z; Stall = stl; Stop = stp;
    branch_target = bt; jump_target = jt;
    it.name = nm; it.src = esrc; it.pc = epc; it.fl = efl;
    sb.push_back(it);
    @(negedge clk);
  endtask

  initial begin : monitor
    exp_t       it;
    logic [1:0] src_s;
    forever begin
      @(negedge clk);
      #3;
      if (sb.size() > 0) begin
        it    = sb.pop_front();
        src_s = PcSrc;
        @(posedge clk);
        #1;
        chk({it.name, "_pcsrc"}, 32'(src_s), 32'(it.src));
        chk({it.name, "_pc"}, 32'(pc), 32'(it.pc));
        chk({it.name, "_flags"}, 32'(flags()), 32'(it.fl));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin : driver
    int wait_cyc;
    exp_t it;
    reset = 1'b1; Type = TO; OPCode = '0; Zero = 0; Stall = 1'b1; Stop = 0;
    branch_target = '0; jump_target = '0;
    #1;
    chk("rst_pc", 32'(pc), 32'h0);
    chk("rst_pcsrc", 32'(PcSrc), 32'h0);
    chk("rst_flags", 32'(flags()), 32'(5'b01000));
    @(negedge clk);
    reset = 1'b0;

    st("j_fffe",  TJ, OP_J,   0, 0, 0, 16'h0000, 16'hFFFE, 2'b10, 16'hFFFE, 5'b01000);
    st("seq_a",   TO, 5'd0,   0, 0, 0, 16'h0000, 16'h0000, 2'b11, 16'hFFFF, 5'b01000);
    st("seq_b",   TO, 5'd0,   0, 0, 0, 16'h0000, 16'h0000, 2'b11, 16'h0000, 5'b01000);
    st("seq_c",   TO, 5'd0,   0, 0, 0, 16'h0000, 16'h0000, 2'b11, 16'h0001, 5'b01000);
    st("beq_t",   TB, OP_BEQ, 1, 0, 0, 16'h0040, 16'h0000, 2'b01, 16'h0040, 5'b01000);
    st("bne_nt",  TB, OP_BNE, 1, 0, 0, 16'h0080, 16'h0000, 2'b11, 16'h0041, 5'b01000);
    st("beq_nt",  TB, OP_BEQ, 0, 0, 0, 16'h0080, 16'h0000, 2'b11, 16'h0042, 5'b01000);
    st("bne_t",   TB, OP_BNE, 0, 0, 0, 16'h0080, 16'h0000, 2'b01, 16'h0080, 5'b01000);
    st("j_bad",   TJ, 5'd7,   0, 0, 0, 16'h0000, 16'h0300, 2'b11, 16'h0081, 5'b01000);
    st("j_10",    TJ, OP_J,   0, 0, 0, 16'h0000, 16'h0010, 2'b10, 16'h0010, 5'b01000);
    st("jal_100", TJ, OP_JAL, 0, 0, 0, 16'h0000, 16'h0100, 2'b10, 16'h0100, 5'b00000);
    st("ret_11",  TR, OP_RET, 0, 0, 0, 16'h0000, 16'h0000, 2'b10, 16'h0011, 5'b01000);

    st("j_1",     TJ, OP_J,   0, 0, 0, 16'h0000, 16'h0001, 2'b10, 16'h0001, 5'b01000);
    st("jal_1",   TJ, OP_JAL, 0, 0, 0, 16'h0000, 16'h0002, 2'b10, 16'h0002, 5'b00000);
    st("jal_2",   TJ, OP_JAL, 0, 0, 0, 16'h0000, 16'h0003, 2'b10, 16'h0003, 5'b00000);
    st("jal_3",   TJ, OP_JAL, 0, 0, 0, 16'h0000, 16'h0004, 2'b10, 16'h0004, 5'b00000);
    st("jal_4",   TJ, OP_JAL, 0, 0, 0, 16'h0000, 16'h0005, 2'b10, 16'h0005, 5'b00100);
    st("jal_5",   TJ, OP_JAL, 0, 0, 0, 16'h0000, 16'h0020, 2'b10, 16'h0020, 5'b00110);
    st("ret_6",   TR, OP_RET, 0, 0, 0, 16'h0000, 16'h0000, 2'b10, 16'h0006, 5'b00010);
    st("ret_5",   TR, OP_RET, 0, 0, 0, 16'h0000, 16'h0000, 2'b10, 16'h0005, 5'b00010);
    st("ret_4",   TR, OP_RET, 0, 0, 0, 16'h0000, 16'h0000, 2'b10, 16'h0004, 5'b00010);
    st("ret_3",   TR, OP_RET, 0, 0, 0, 16'h0000, 16'h0000, 2'b10, 16'h0003, 5'b01010);
    st("ret_unf", TR, OP_RET, 0, 0, 0, 16'h0000, 16'h0000, 2'b11, 16'h0004, 5'b01011);

    st("stall_jal", TJ, OP_JAL, 0, 1, 0, 16'h0000, 16'h0200, 2'b00, 16'h0004, 5'b01011);
    st("post_stall", TO, 5'd0,  0, 0, 0, 16'h0000, 16'h0000, 2'b11, 16'h0005, 5'b01011);
    st("stop",      TO, 5'd0,   0, 0, 1, 16'h0000, 16'h0000, 2'b00, 16'h0005, 5'b11011);
    st("halt_hold", TO, 5'd0,   0, 0, 0, 16'h0000, 16'h0000, 2'b00, 16'h0005, 5'b11011);
    st("halt_jal",  TJ, OP_JAL, 0, 0, 0, 16'h0000, 16'h0200, 2'b00, 16'h0005, 5'b11011);

    // Asynchronous reset mid-halt; the following edge decodes normally.
    Type = TO; OPCode = '0; Zero = 0; Stall = 0; Stop = 0;
    it.name = "rst_edge"; it.src = 2'b00; it.pc = 16'h0001; it.fl = 5'b01000;
    sb.push_back(it);
    #2 reset = 1'b1;
    #1;
    chk("arst_pc", 32'(pc), 32'h0);
    chk("arst_halted", 32'(halted), 32'h0);
    chk("arst_flags", 32'(flags()), 32'(5'b01000));
    #1 reset = 1'b0;
    @(negedge clk);
    st("post_rst", TO, 5'd0, 0, 0, 0, 16'h0000, 16'h0000, 2'b11, 16'h0002, 5'b01000);

    wait_cyc = 0;
    while (sb.size() > 0 && wait_cyc < 10) begin
      @(negedge clk);
      wait_cyc++;
    end
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain got %0d pending expected 0", sb.size());
    end
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
